// File: rtl/display_buttons_pkg.sv
// Shared types and register map for the display-board button scanner.
package display_board_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_UPDATE
    } scan_state_t;

    localparam logic REG_BUTTONS = 1'b0;
    localparam logic REG_PENDING = 1'b1;

endpackage

// File: rtl/display_buttons_if.sv
// Avalon-MM register port of the button scanner (read-only, fixed 1-cycle latency).
interface display_buttons_if;

    logic        avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;

    modport master (output avs_address, avs_read, input avs_readdata);
    modport slave  (input avs_address, avs_read, output avs_readdata);

endinterface

// File: rtl/display_buttons_debounce.sv
// Scan-rate debouncer: accepts a captured vector once it has repeated for DEBOUNCE_SCANS scans.
module button_debounce #(
    parameter int unsigned NUM_BITS       = 16,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    localparam int unsigned CNT_W         = $clog2(DEBOUNCE_SCANS + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_BITS-1:0] raw,
    input  logic                update,
    output logic [CNT_W-1:0]    stable_cnt,
    output logic [NUM_BITS-1:0] prev_raw,
    output logic [NUM_BITS-1:0] buttons,
    output logic [NUM_BITS-1:0] change
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_BITS-1:0] prev_raw_q, prev_raw_d;
    logic [NUM_BITS-1:0] buttons_q, buttons_d;

    always_comb begin
        cnt_d      = cnt_q;
        prev_raw_d = prev_raw_q;
        buttons_d  = buttons_q;
        change     = '0;
        if (update) begin
            if (raw == prev_raw_q) begin
                cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
            end else begin
                cnt_d = CNT_W'(1);
            end
            prev_raw_d = raw;
            // Acceptance uses the freshly updated count, so the Nth identical scan commits.
            if ((cnt_d >= CNT_MAX) && (raw != buttons_q)) begin
                buttons_d = raw;
                change    = raw ^ buttons_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            prev_raw_q <= '0;
            buttons_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            prev_raw_q <= prev_raw_d;
            buttons_q  <= buttons_d;
        end
    end

    assign stable_cnt = cnt_q;
    assign prev_raw   = prev_raw_q;
    assign buttons    = buttons_q;

endmodule

// File: rtl/display_buttons.sv
// Display-board button scanner: drives the load/clock pins of the shift chain, captures
// SHIFT_OUT, debounces the vector and exposes it over Avalon-MM with a change interrupt.
module display_buttons
    import display_board_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 25,
    parameter int unsigned NUM_BITS       = 16,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    display_buttons_if.slave    avs,
    output logic                shift_load,
    output logic                shift_clkin,
    input  logic                shift_out,
    output logic [NUM_BITS-1:0] buttons,
    output logic                irq
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BITS - 1);

    scan_state_t         state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_BITS-1:0] raw_q, raw_d;
    logic [1:0]          sync_q, sync_d;
    logic                shift_load_q, shift_load_d;
    logic                shift_clkin_q, shift_clkin_d;
    logic [NUM_BITS-1:0] pending_q, pending_d;
    logic [31:0]         readdata_q, readdata_d;
    logic                irq_q, irq_d;

    logic                div_last;
    logic                update;
    logic [NUM_BITS-1:0] change;
    logic [NUM_BITS-1:0] clr;
    logic [CNT_W-1:0]    stable_cnt;
    logic [NUM_BITS-1:0] prev_raw;

    assign div_last = (div_q == DIV_LAST);
    assign update   = (state_q == ST_UPDATE);
    assign sync_d   = {sync_q[0], shift_out};

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        idx_d   = idx_q;
        raw_d   = raw_q;
        if (state_q != ST_UPDATE) begin
            div_d = div_last ? '0 : div_q + 1'b1;
        end
        case (state_q)
            ST_LOAD: begin
                if (div_last) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (div_last) begin
                    state_d = ST_SHIFT_LO;
                    idx_d   = '0;
                end
            end
            ST_SHIFT_LO: begin
                if (div_last) begin
                    raw_d[IDX_LAST - idx_q] = ~sync_q[1];
                    state_d = (idx_q == IDX_LAST) ? ST_UPDATE : ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (div_last) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_UPDATE: state_d = ST_LOAD;
            default:   state_d = ST_LOAD;
        endcase
        // Pins are registered from the current state, so they trail the FSM by one cycle.
        shift_load_d  = (state_q != ST_LOAD);
        shift_clkin_d = (state_q == ST_SHIFT_HI);
    end

    always_comb begin
        clr        = (avs.avs_read && (avs.avs_address == REG_PENDING)) ? pending_q : '0;
        pending_d  = (pending_q & ~clr) | change;
        irq_d      = |pending_q;
        readdata_d = readdata_q;
        if (avs.avs_read) begin
            readdata_d = '0;
            if (avs.avs_address == REG_PENDING) begin
                readdata_d[NUM_BITS-1:0] = pending_q;
            end else begin
                readdata_d[NUM_BITS-1:0] = buttons;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_LOAD;
            div_q         <= '0;
            idx_q         <= '0;
            raw_q         <= '0;
            sync_q        <= '1;
            shift_load_q  <= 1'b1;
            shift_clkin_q <= 1'b0;
            pending_q     <= '0;
            readdata_q    <= '0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            idx_q         <= idx_d;
            raw_q         <= raw_d;
            sync_q        <= sync_d;
            shift_load_q  <= shift_load_d;
            shift_clkin_q <= shift_clkin_d;
            pending_q     <= pending_d;
            readdata_q    <= readdata_d;
            irq_q         <= irq_d;
        end
    end

    button_debounce #(
        .NUM_BITS       (NUM_BITS),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .reset_n    (reset_n),
        .raw        (raw_q),
        .update     (update),
        .stable_cnt (stable_cnt),
        .prev_raw   (prev_raw),
        .buttons    (buttons),
        .change     (change)
    );

    // Once a vector has been stable long enough, the debounced output must equal it.
    assert property (@(posedge clk) disable iff (!reset_n)
        (stable_cnt < CNT_W'(DEBOUNCE_SCANS)) || (buttons == prev_raw));

    assign shift_load       = shift_load_q;
    assign shift_clkin      = shift_clkin_q;
    assign avs.avs_readdata = readdata_q;
    assign irq              = irq_q;

endmodule

// File: tb/tb_display_buttons.sv
// Directed bench for display_buttons: 74HC165-style chain model, pin timing, debounce and register checks.
module tb_display_buttons;
    import display_board_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        shift_load, shift_clkin, shift_out;
    logic [15:0] buttons;
    logic        irq;

    logic [15:0] pat = 16'hA5F0;
    logic [15:0] chain = '1;
    logic        clkin_d = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    int load_low, rises, hi_min, hi_max, period;

    display_buttons_if bus();

    display_buttons #(
        .CLK_DIV        (25),
        .NUM_BITS       (16),
        .DEBOUNCE_SCANS (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .avs         (bus.slave),
        .shift_load  (shift_load),
        .shift_clkin (shift_clkin),
        .shift_out   (shift_out),
        .buttons     (buttons),
        .irq         (irq)
    );

    always #10 clk = ~clk;

    // Chain model: parallel load while SH/LD low (buttons active low), shift toward MSB on clock rise.
    always @(posedge clk) begin
        clkin_d <= shift_clkin;
        if (!shift_load) chain <= ~pat;
        else if (shift_clkin && !clkin_d) chain <= {chain[14:0], 1'b1};
    end
    assign shift_out = chain[15];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic addr, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        bus.avs_address = addr;
        bus.avs_read    = 1'b1;
        @(negedge clk);
        bus.avs_read    = 1'b0;
        check(tag, bus.avs_readdata, exp_q.pop_front());
    endtask

    task automatic wait_fall(input string tag);
        logic prev;
        bit   seen;
        prev = shift_load;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (prev && !shift_load) seen = 1'b1;
            prev = shift_load;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    // Called on the first sample after a load fall; returns at the next load fall.
    task automatic measure_scan(output int ll, output int rs, output int hmin,
                                output int hmax, output int per);
        logic prev_load, prev_clk;
        bit   first_low, done;
        int   hi_run;
        ll = 1; rs = 0; hmin = 9999; hmax = 0; per = 0; hi_run = 0;
        first_low = 1'b1; done = 1'b0;
        prev_load = shift_load; prev_clk = shift_clkin;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            per++;
            if (prev_load && !shift_load) begin
                done = 1'b1;
            end else begin
                if (first_low) begin
                    if (!shift_load) ll++;
                    else first_low = 1'b0;
                end
                if (shift_clkin) begin
                    if (!prev_clk) rs++;
                    hi_run++;
                end else if (prev_clk) begin
                    if (hi_run < hmin) hmin = hi_run;
                    if (hi_run > hmax) hmax = hi_run;
                    hi_run = 0;
                end
            end
            prev_load = shift_load;
            prev_clk  = shift_clkin;
        end
    endtask

    task automatic check_scan(input string tag);
        measure_scan(load_low, rises, hi_min, hi_max, period);
        check({tag, "_load_low"}, 32'(load_low), 32'd25);
        check({tag, "_rises"},    32'(rises),    32'd15);
        check({tag, "_hi_min"},   32'(hi_min),   32'd25);
        check({tag, "_hi_max"},   32'(hi_max),   32'd25);
        check({tag, "_period"},   32'(period),   32'd826);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_load"},     32'(shift_load),  32'd1);
        check({tag, "_clkin"},    32'(shift_clkin), 32'd0);
        check({tag, "_buttons"},  32'(buttons),     32'd0);
        check({tag, "_irq"},      32'(irq),         32'd0);
        check({tag, "_readdata"}, bus.avs_readdata, 32'd0);
    endtask

    initial begin
        bus.avs_read    = 1'b0;
        bus.avs_address = REG_BUTTONS;
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_state("rst");
        repeat (5) @(negedge clk);
        reset_n = 1'b1;

        // Scan 1 starts on the first edge after release.
        wait_fall("first_fall");
        check_scan("scan1");
        check("scan1_buttons", 32'(buttons), 32'd0);
        wait_fall("fall3");
        wait_fall("fall4");
        check("scan3_buttons", 32'(buttons), 32'd0);
        check("scan3_irq", 32'(irq), 32'd0);
        wait_fall("fall5");
        check("scan4_buttons", 32'(buttons), 32'h0000A5F0);
        check("scan4_irq", 32'(irq), 32'd1);

        do_read(REG_PENDING, 32'h0000A5F0, "pending_first");
        check("irq_after_read", 32'(irq), 32'd1);
        @(negedge clk);
        check("irq_cleared", 32'(irq), 32'd0);
        do_read(REG_PENDING, 32'h0, "pending_cleared");
        do_read(REG_BUTTONS, 32'h0000A5F0, "buttons_reg");

        // Bit 3 bounces for six scans, then settles pressed.
        for (int i = 0; i < 6; i++) begin
            pat = (i % 2 == 0) ? 16'hA5F8 : 16'hA5F0;
            wait_fall("bounce_fall");
            check("bounce_buttons", 32'(buttons), 32'h0000A5F0);
        end
        pat = 16'hA5F8;
        for (int i = 0; i < 3; i++) begin
            wait_fall("settle_fall");
            check("settle_buttons", 32'(buttons), 32'h0000A5F0);
        end
        wait_fall("settled_fall");
        check("settled_buttons", 32'(buttons), 32'h0000A5F8);
        check("settled_irq", 32'(irq), 32'd1);

        // Bit 0 commits on the 4th scan's UPDATE; land the clearing read on that exact cycle.
        pat = 16'hA5F9;
        for (int i = 0; i < 3; i++) wait_fall("bit0_fall");
        repeat (824) @(negedge clk);
        check("pre_update_buttons", 32'(buttons), 32'h0000A5F8);
        do_read(REG_PENDING, 32'h00000008, "sim_read_old_pending");
        check("sim_buttons", 32'(buttons), 32'h0000A5F9);
        check("sim_irq0", 32'(irq), 32'd1);
        @(negedge clk);
        check("sim_irq1", 32'(irq), 32'd1);
        do_read(REG_PENDING, 32'h00000001, "sim_bit0_retained");

        // Reset during SHIFT_HI of bit 7.
        wait_fall("pre_midscan_fall");
        repeat (434) @(negedge clk);
        check("midscan_in_hi", 32'(shift_clkin), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_fall("post_rst_fall");
        check_scan("rescan");
        check("rescan_buttons", 32'(buttons), 32'd0);
        wait_fall("rescan_fall3");
        wait_fall("rescan_fall4");
        check("rescan3_buttons", 32'(buttons), 32'd0);
        wait_fall("rescan_fall5");
        check("rescan4_buttons", 32'(buttons), 32'h0000A5F9);
        check("rescan4_irq", 32'(irq), 32'd1);
        do_read(REG_PENDING, 32'h0000A5F9, "rescan_pending");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
